// File: rtl/mmio_uart_responder.sv
// MMIO responder for the CPU I/O window: an 8N1 UART with a transmit FIFO,
// a single-byte receive holding register and a programmable baud divisor.
module mmio_uart_responder #(
   parameter int TX_DEPTH    = 16,
   parameter int DEFAULT_DIV = 868
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  io_addr,
   input  logic [31:0] io_dout,
   output logic [31:0] io_din,
   input  logic        io_we,
   input  logic        io_rd,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam int AW          = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam int CW          = AW + 1;
   localparam int SYNC_STAGES = 2;

   localparam logic [7:0] ADDR_TX_DATA  = 8'h00;
   localparam logic [7:0] ADDR_TX_STAT  = 8'h04;
   localparam logic [7:0] ADDR_RX_DATA  = 8'h08;
   localparam logic [7:0] ADDR_RX_STAT  = 8'h0C;
   localparam logic [7:0] ADDR_BAUD_DIV = 8'h10;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   logic unused_dout_hi;
   assign unused_dout_hi = ^io_dout[31:16];

   // Access decode
   logic wr_tx, wr_div, rd_txstat, rd_rxdata, rd_rxstat;
   assign wr_tx     = io_we && (io_addr == ADDR_TX_DATA);
   assign wr_div    = io_we && (io_addr == ADDR_BAUD_DIV);
   assign rd_txstat = io_rd && (io_addr == ADDR_TX_STAT);
   assign rd_rxdata = io_rd && (io_addr == ADDR_RX_DATA);
   assign rd_rxstat = io_rd && (io_addr == ADDR_RX_STAT);

   logic [15:0] div_reg;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_reg <= 16'(DEFAULT_DIV);
      end else if (wr_div) begin
         div_reg <= (io_dout[15:0] < 16'd4) ? 16'd4 : io_dout[15:0];
      end
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;
   logic          pop, push_ok, fifo_empty, fifo_ready;

   assign fifo_empty = (count_reg == '0);
   assign fifo_ready = (count_reg < CW'(TX_DEPTH));
   // A full FIFO still takes a byte when the transmitter frees a slot this cycle
   assign push_ok    = wr_tx && (fifo_ready || pop);

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_reg] <= io_dout[7:0];
   end

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
      end
   end

   // ---------------- TX FSM ----------------
   tx_state_t   tx_state_reg, tx_state_next;
   logic [15:0] tx_timer_reg, tx_timer_next;
   logic [2:0]  tx_bit_reg, tx_bit_next;
   logic [7:0]  tx_shift_reg, tx_shift_next;
   logic        tx_out_reg, tx_out_next;
   logic        tx_bit_end;

   assign tx_bit_end = (tx_timer_reg == 16'd0);

   always_comb begin
      tx_state_next = tx_state_reg;
      tx_timer_next = tx_timer_reg;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      tx_out_next   = tx_out_reg;
      pop           = 1'b0;
      case (tx_state_reg)
         TX_IDLE: begin
            tx_out_next = 1'b1;
            if (!fifo_empty) begin
               pop           = 1'b1;
               tx_shift_next = fifo_mem[rd_ptr_reg];
               tx_timer_next = div_reg - 16'd1;
               tx_state_next = TX_START;
               tx_out_next   = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_next = TX_DATA;
               tx_timer_next = div_reg - 16'd1;
               tx_bit_next   = 3'd0;
               tx_out_next   = tx_shift_reg[0];
            end else begin
               tx_timer_next = tx_timer_reg - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_timer_next = div_reg - 16'd1;
               if (tx_bit_reg == 3'd7) begin
                  tx_state_next = TX_STOP;
                  tx_out_next   = 1'b1;
               end else begin
                  tx_bit_next   = tx_bit_reg + 3'd1;
                  tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                  tx_out_next   = tx_shift_reg[1];
               end
            end else begin
               tx_timer_next = tx_timer_reg - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               // Chain straight into the next start bit when more data waits
               if (!fifo_empty) begin
                  pop           = 1'b1;
                  tx_shift_next = fifo_mem[rd_ptr_reg];
                  tx_timer_next = div_reg - 16'd1;
                  tx_state_next = TX_START;
                  tx_out_next   = 1'b0;
               end else begin
                  tx_state_next = TX_IDLE;
                  tx_out_next   = 1'b1;
               end
            end else begin
               tx_timer_next = tx_timer_reg - 16'd1;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_state_reg <= TX_IDLE;
         tx_timer_reg <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         tx_out_reg   <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_timer_reg <= tx_timer_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         tx_out_reg   <= tx_out_next;
      end
   end

   assign uart_tx = tx_out_reg;

   // ---------------- RX synchronizer ----------------
   logic [SYNC_STAGES-1:0] rx_sync_reg;
   logic                   rx_s;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk or negedge rstn) begin
               if (!rstn) rx_sync_reg[gi] <= 1'b1;
               else       rx_sync_reg[gi] <= uart_rx;
            end
         end else begin : g_rest
            always_ff @(posedge clk or negedge rstn) begin
               if (!rstn) rx_sync_reg[gi] <= 1'b1;
               else       rx_sync_reg[gi] <= rx_sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign rx_s = rx_sync_reg[SYNC_STAGES-1];

   // ---------------- RX FSM ----------------
   rx_state_t   rx_state_reg, rx_state_next;
   logic [15:0] rx_timer_reg, rx_timer_next;
   logic [2:0]  rx_bit_reg, rx_bit_next;
   logic [7:0]  rx_shift_reg, rx_shift_next;
   logic        rx_load, rx_frame_err, rx_sample;

   assign rx_sample = (rx_timer_reg == 16'd0);

   always_comb begin
      rx_state_next = rx_state_reg;
      rx_timer_next = rx_timer_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_load       = 1'b0;
      rx_frame_err  = 1'b0;
      case (rx_state_reg)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_state_next = RX_START;
               rx_timer_next = (div_reg >> 1) - 16'd1;
            end
         end
         RX_START: begin
            if (rx_sample) begin
               rx_state_next = rx_s ? RX_IDLE : RX_DATA;
               rx_timer_next = div_reg - 16'd1;
               rx_bit_next   = 3'd0;
            end else begin
               rx_timer_next = rx_timer_reg - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_sample) begin
               rx_shift_next = {rx_s, rx_shift_reg[7:1]};
               rx_timer_next = div_reg - 16'd1;
               if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
               else                    rx_bit_next   = rx_bit_reg + 3'd1;
            end else begin
               rx_timer_next = rx_timer_reg - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_sample) begin
               rx_state_next = RX_IDLE;
               rx_load       = rx_s;
               rx_frame_err  = !rx_s;
            end else begin
               rx_timer_next = rx_timer_reg - 16'd1;
            end
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end

   // ---------------- Status flags ----------------
   logic [7:0] rx_byte_reg;
   logic       rx_valid_reg, rx_ovr_reg, rx_ferr_reg, tx_ovf_reg;
   logic       rx_valid_next, rx_ovr_next, rx_ferr_next, tx_ovf_next;

   // Set wins over a same-cycle clearing read; a byte landing during an
   // RX_DATA read replaces the one being read without counting as overrun.
   always_comb begin
      rx_valid_next = rx_load | (rx_valid_reg & ~rd_rxdata);
      rx_ovr_next   = (rx_load & rx_valid_reg & ~rd_rxdata) | (rx_ovr_reg & ~rd_rxstat);
      rx_ferr_next  = rx_frame_err | (rx_ferr_reg & ~rd_rxstat);
      tx_ovf_next   = (wr_tx & ~push_ok) | (tx_ovf_reg & ~rd_txstat);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_state_reg <= RX_IDLE;
         rx_timer_reg <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
         rx_byte_reg  <= '0;
         rx_valid_reg <= 1'b0;
         rx_ovr_reg   <= 1'b0;
         rx_ferr_reg  <= 1'b0;
         tx_ovf_reg   <= 1'b0;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_timer_reg <= rx_timer_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         if (rx_load) rx_byte_reg <= rx_shift_reg;
         rx_valid_reg <= rx_valid_next;
         rx_ovr_reg   <= rx_ovr_next;
         rx_ferr_reg  <= rx_ferr_next;
         tx_ovf_reg   <= tx_ovf_next;
      end
   end

   // ---------------- Read mux ----------------
   logic tx_busy;
   assign tx_busy = (tx_state_reg != TX_IDLE) || !fifo_empty;

   always_comb begin
      io_din = 32'h0;
      case (io_addr)
         ADDR_TX_STAT:  io_din = {22'h0, 6'(count_reg), 1'b0, tx_ovf_reg, tx_busy, fifo_ready};
         ADDR_RX_DATA:  io_din = {24'h0, rx_byte_reg};
         ADDR_RX_STAT:  io_din = {29'h0, rx_ferr_reg, rx_ovr_reg, rx_valid_reg};
         ADDR_BAUD_DIV: io_din = {16'h0, div_reg};
         default:       io_din = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Self-checking bench for mmio_uart_responder: a frame-timeline model of the
// transmitter and a flag model of the receiver, compared every cycle and per access.
module tb_mmio_uart_responder;

   localparam int DEPTH   = 16;
   localparam int DEF_DIV = 868;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  io_addr = 8'h04;
   logic [31:0] io_dout = '0;
   logic [31:0] io_din;
   logic        io_we = 1'b0;
   logic        io_rd = 1'b0;
   logic        uart_tx;
   logic        uart_rx;
   logic        rx_drv = 1'b1;
   logic        loop = 1'b0;

   assign uart_rx = loop ? uart_tx : rx_drv;

   mmio_uart_responder #(.TX_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
      .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
      .io_we(io_we), .io_rd(io_rd), .uart_tx(uart_tx), .uart_rx(uart_rx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests_run = 0;
   int tests_failed = 0;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   // Each accepted byte is a frame: accepted at edge acc, starts at edge start,
   // occupies 10*div cycles. FIFO occupancy and busy follow from that timeline.
   int         f_acc[$];
   int         f_start[$];
   int         f_div[$];
   logic [7:0] f_byte[$];
   int         last_end = 0;
   int         m_div = DEF_DIV;
   bit         m_ovf, m_rv, m_ovr, m_ferr;
   logic [7:0] m_rb;
   bit         chk_en = 0;
   int         last_wr_edge = 0;

   function automatic int m_count(int e);
      int n = 0;
      foreach (f_start[i]) if (f_acc[i] <= e && f_start[i] > e) n++;
      return n;
   endfunction

   function automatic bit m_busy(int e);
      foreach (f_start[i]) if (f_acc[i] <= e && f_start[i] + 10 * f_div[i] > e) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_tx(int t);
      logic [7:0] b;
      int idx;
      foreach (f_start[i]) begin
         if (t >= f_start[i] && t < f_start[i] + 10 * f_div[i]) begin
            idx = (t - f_start[i]) / f_div[i];
            b = f_byte[i];
            if (idx == 0) return 1'b0;
            if (idx == 9) return 1'b1;
            return b[idx-1];
         end
      end
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_txstat(int e);
      logic [31:0] v = '0;
      int c = m_count(e);
      v[0]   = (c < DEPTH);
      v[1]   = m_busy(e);
      v[2]   = m_ovf;
      v[9:4] = 6'(c);
      return v;
   endfunction

   function automatic logic [31:0] m_read(logic [7:0] a);
      case (a)
         8'h04:   return m_txstat(cyc);
         8'h08:   return {24'h0, m_rb};
         8'h0C:   return {29'h0, m_ferr, m_ovr, m_rv};
         8'h10:   return 32'(m_div);
         default: return 32'h0;
      endcase
   endfunction

   function automatic void m_push(int k, logic [7:0] b);
      int  c = m_count(k - 1);
      bit  popk = 0;
      int  s;
      foreach (f_start[i]) if (f_start[i] == k) popk = 1;
      if (c < DEPTH || popk) begin
         s = (k + 1 > last_end) ? k + 1 : last_end;
         f_acc.push_back(k);
         f_start.push_back(s);
         f_div.push_back(m_div);
         f_byte.push_back(b);
         last_end = s + 10 * m_div;
      end else begin
         m_ovf = 1;
      end
   endfunction

   function automatic void m_rx_byte(logic [7:0] b);
      if (m_rv) m_ovr = 1;
      m_rb = b;
      m_rv = 1;
   endfunction

   function automatic void m_clear();
      f_acc.delete(); f_start.delete(); f_div.delete(); f_byte.delete();
      last_end = 0;
      m_div = DEF_DIV;
      m_ovf = 0; m_rv = 0; m_ovr = 0; m_ferr = 0; m_rb = 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      tests_run++;
      if (got !== expv) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   // Continuous compare: serial line always, TX_STAT whenever the bus idles on it
   always @(negedge clk) begin
      if (chk_en) begin
         check("uart_tx", {31'h0, uart_tx}, {31'h0, m_tx(cyc)});
         if (io_addr == 8'h04) check("tx_stat_live", io_din, m_txstat(cyc));
      end
   end

   // ---------------- bus / line tasks (start and end at posedge+1) ----------------
   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      io_addr = a; io_dout = d; io_we = 1'b1;
      @(posedge clk);
      #1;
      last_wr_edge = cyc;
      io_we = 1'b0; io_addr = 8'h04;
      if (a == 8'h00) m_push(last_wr_edge, d[7:0]);
      if (a == 8'h10) m_div = (d[15:0] < 16'd4) ? 4 : int'(d[15:0]);
      $display("[TB] wr addr=0x%02h data=0x%08h edge=%0d", a, d, last_wr_edge);
   endtask

   task automatic read_chk(input logic [7:0] a, input string name, output logic [31:0] got);
      logic [31:0] expv;
      expv = m_read(a);
      io_addr = a; io_rd = 1'b1;
      #1;
      got = io_din;
      check(name, got, expv);
      @(posedge clk);
      #1;
      io_rd = 1'b0; io_addr = 8'h04;
      if (a == 8'h04) m_ovf = 0;
      if (a == 8'h08) m_rv = 0;
      if (a == 8'h0C) begin m_ovr = 0; m_ferr = 0; end
      $display("[TB] rd addr=0x%02h data=0x%08h", a, got);
   endtask

   task automatic wait_tx_idle();
      int guard = 0;
      while (m_busy(cyc) && guard < 40000) begin
         wait_cycles(1);
         guard++;
      end
      check("tx_idle_bound", {31'h0, m_busy(cyc)}, 32'h0);
      f_acc.delete(); f_start.delete(); f_div.delete(); f_byte.delete();
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop_ok);
      $display("[TB] rx frame byte=0x%02h stop=%0b div=%0d", b, stop_ok, m_div);
      rx_drv = 1'b0;
      wait_cycles(m_div);
      for (int j = 0; j < 8; j++) begin
         rx_drv = b[j];
         wait_cycles(m_div);
      end
      rx_drv = stop_ok;
      wait_cycles(m_div);
      rx_drv = 1'b1;
      wait_cycles(2 * m_div + 4);
      if (stop_ok) m_rx_byte(b);
      else         m_ferr = 1;
   endtask

   task automatic rx_glitch();
      $display("[TB] rx glitch");
      rx_drv = 1'b0;
      wait_cycles(1);
      rx_drv = 1'b1;
      wait_cycles(m_div + 4);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rv;
   logic [9:0]  lit;
   int          k0, n, d;

   initial begin
      m_clear();
      wait_cycles(3);
      rstn = 1'b1;
      chk_en = 1;

      // reset state
      read_chk(8'h04, "reset_txstat", rv);
      check("reset_txstat_lit", rv, 32'h1);
      read_chk(8'h10, "reset_div", rv);
      check("reset_div_lit", rv, 32'd868);
      check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);

      // single frame, bit-by-bit literal pattern of 0xA5
      bus_write(8'h10, 32'd8);
      bus_write(8'h00, 32'hA5);
      k0  = last_wr_edge;
      lit = {1'b1, 8'hA5, 1'b0};
      for (int t = 0; t < 10; t++) begin
         wait_cycles(k0 + 1 + t * 8 + 4 - cyc);
         check("frame_a5_bit", {31'h0, uart_tx}, {31'h0, lit[t]});
      end
      wait_cycles(k0 + 80 - cyc);
      check("busy_before_end", {31'h0, io_din[1]}, 32'h1);
      wait_cycles(1);
      check("busy_after_end", {31'h0, io_din[1]}, 32'h0);
      wait_tx_idle();

      // FIFO full and overflow
      for (int i = 0; i < 18; i++) bus_write(8'h00, {24'h0, 8'(i * 13 + 7)});
      read_chk(8'h04, "ovf_stat", rv);
      check("ovf_stat_lit", rv, 32'h106);
      read_chk(8'h04, "ovf_clear", rv);
      check("ovf_clear_lit", rv, 32'h102);
      wait_tx_idle();

      // divisor clamp
      bus_write(8'h10, 32'd2);
      read_chk(8'h10, "div_clamp", rv);
      check("div_clamp_lit", rv, 32'd4);
      bus_write(8'h10, 32'd8);

      // loopback and overrun
      loop = 1'b1;
      bus_write(8'h00, 32'h3C);
      wait_tx_idle();
      wait_cycles(2 * m_div + 4);
      m_rx_byte(8'h3C);
      read_chk(8'h0C, "lb_rxstat", rv);   check("lb_rxstat_lit", rv, 32'h1);
      read_chk(8'h08, "lb_rxdata", rv);   check("lb_rxdata_lit", rv, 32'h3C);
      read_chk(8'h0C, "lb_rxstat2", rv);  check("lb_rxstat2_lit", rv, 32'h0);
      bus_write(8'h00, 32'h11);
      bus_write(8'h00, 32'h22);
      wait_tx_idle();
      wait_cycles(2 * m_div + 4);
      m_rx_byte(8'h11);
      m_rx_byte(8'h22);
      read_chk(8'h08, "ovr_rxdata", rv);  check("ovr_rxdata_lit", rv, 32'h22);
      read_chk(8'h0C, "ovr_rxstat", rv);  check("ovr_rxstat_lit", rv, 32'h2);
      loop = 1'b0;

      // framing error and glitch
      rx_frame(8'h55, 1'b0);
      read_chk(8'h0C, "ferr_rxstat", rv); check("ferr_rxstat_lit", rv, 32'h4);
      rx_glitch();
      read_chk(8'h0C, "glitch_rxstat", rv); check("glitch_rxstat_lit", rv, 32'h0);

      // randomized traffic
      for (int it = 0; it < 6; it++) begin
         d = $urandom_range(0, 12);
         bus_write(8'h10, {16'($urandom), 16'(d)});
         read_chk(8'h10, "rnd_div", rv);
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) begin
            bus_write(8'h00, $urandom);
            wait_cycles($urandom_range(0, 2));
         end
         read_chk(8'h04, "rnd_txstat_busy", rv);
         wait_tx_idle();
         read_chk(8'h04, "rnd_txstat_idle", rv);
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) rx_glitch();
            rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
         end
         if ($urandom_range(0, 1) == 1) begin
            read_chk(8'h08, "rnd_rxdata", rv);
            read_chk(8'h0C, "rnd_rxstat", rv);
         end else begin
            read_chk(8'h0C, "rnd_rxstat", rv);
            read_chk(8'h08, "rnd_rxdata", rv);
         end
         bus_write(8'h14, $urandom);
         read_chk(8'h14, "rnd_unmapped", rv);
         read_chk(8'h00, "rnd_txdata_rd", rv);
      end

      // reset in the middle of a frame
      bus_write(8'h10, 32'd8);
      bus_write(8'h00, 32'h00);
      bus_write(8'h00, 32'h5A);
      bus_write(8'h00, 32'hC3);
      wait_cycles(last_wr_edge - 2 + 30 - cyc);
      check("midframe_low", {31'h0, uart_tx}, 32'h0);
      chk_en = 0;
      rstn = 1'b0;
      #1;
      check("async_reset_tx", {31'h0, uart_tx}, 32'h1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      m_clear();
      chk_en = 1;
      read_chk(8'h04, "post_reset_txstat", rv); check("post_reset_txstat_lit", rv, 32'h1);
      read_chk(8'h10, "post_reset_div", rv);    check("post_reset_div_lit", rv, 32'd868);
      wait_cycles(20);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mmio_uart_responder.md
# mmio_uart_responder

Bus-side responder for the CPU's memory-mapped I/O port: it decodes `io_addr` and services `io_rd`/`io_we` strobes, which the CPU issues for addresses ≥ 0x3000. It owns a UART in 8N1 format: a transmit path with a FIFO, a single-byte receive path and a programmable baud divisor. It sits beside the CPU top level, with its `io_*` ports wired straight to the CPU's `io_*` ports.

## Interface
- `TX_DEPTH`, default 16: TX FIFO depth in bytes; must be a power of 2.
- `DEFAULT_DIV`, default 868: reset value of BAUD_DIV, in clock cycles per bit.
- `clk`  in  1  single clock for the whole block.
- `rstn`  in  1  reset, asynchronous, active-low.
- `io_addr`  in  8  byte offset of the register.
- `io_dout`  in  32  write data from the CPU; only bits [15:0] are used.
- `io_din`  out  32  read data to the CPU; combinational from `io_addr` and the current register state.
- `io_we`  in  1  write strobe; one cycle per store.
- `io_rd`  in  1  read strobe; one cycle per load.
- `uart_tx`  out  1  serial output; idles high.
- `uart_rx`  in  1  serial input; asynchronous to `clk`.

## Operation
- Register map (full 8-bit compare):
  - 0x00 TX_DATA, write only: push `io_dout[7:0]` into the FIFO. Reads return 0.
  - 0x04 TX_STAT, read: {22'h0, count[5:0], 1'b0, ovf, busy, ready}.
    - `ready`: FIFO not full.
    - `busy`: TX FSM is not IDLE, or the FIFO is not empty.
    - `ovf`: sticky; set when a push is dropped. Cleared by reading TX_STAT.
  - 0x08 RX_DATA, read: {24'h0, rx_byte}. The read clears `rx_valid`.
  - 0x0C RX_STAT, read: {29'h0, ferr, ovr, rx_valid}. `ovr` and `ferr` are sticky and are cleared by reading RX_STAT.
  - 0x10 BAUD_DIV, read/write: {16'h0, div}.
    - A written value below 4 is stored as 4.
    - Any other value is stored as written (`io_dout[15:0]`).
  - Any other offset: reads return 0; writes are ignored.
- Side effects occur at the clock edge where a strobe is high. Each cycle with a strobe high counts as one access.
- TX FIFO push rule:
  - A push is accepted if count < TX_DEPTH, or if the TX FSM pops in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set.
- TX FSM, states IDLE → START → DATA → STOP:
  - IDLE: if the FIFO is non-empty, pop one byte into the shift register and go to START.
  - START: drive `uart_tx` low.
  - DATA: send 8 bits, LSB first.
  - STOP: drive `uart_tx` high.
  - Each bit lasts exactly `div` cycles.
  - At the end of STOP: go straight to START with a new pop if the FIFO is non-empty, otherwise go to IDLE.
- RX path:
  - `uart_rx` passes through a 2-flop synchronizer.
  - RX FSM states are IDLE → START → DATA → STOP.
  - IDLE: a synchronized low moves the FSM to START.
  - START: wait `div/2` cycles (floor), then sample.
    - Sample high: return to IDLE (glitch).
    - Sample low: go to DATA.
  - DATA: sample 8 bits, one every `div` cycles, LSB first.
  - STOP: sample after `div` cycles.
    - Stop bit high: load `rx_byte` and set `rx_valid`. If `rx_valid` was already 1, also set `ovr`; the new byte overwrites the old one.
    - Stop bit low: set `ferr` and discard the byte.
    - In both cases return to IDLE immediately.
- Divisor handling:
  - Each bit counter loads the current `div` at the start of every bit.
  - A BAUD_DIV write during a frame takes effect at the next bit boundary.
- Simultaneous events:
  - An RX_DATA read in the same cycle as a new byte being loaded: the new byte wins, `rx_valid` stays 1, and `ovr` is not set.
  - A sticky flag being set in the same cycle as its clearing read: the flag stays 1.

## Timing
- Reset values:
  - `uart_tx` = 1.
  - FIFO empty; count = 0.
  - TX and RX FSMs in IDLE.
  - `rx_byte` = 0; `rx_valid`, `ovf`, `ovr`, `ferr` all 0.
  - `div` = DEFAULT_DIV.
  - `io_din` follows the decode of these values (TX_STAT reads 0x1).
- Reads have zero latency: `io_din` is valid in the same cycle as `io_addr`, so the CPU captures it at the MEM/WB edge.
- TX latency when the FSM is IDLE:
  - A TX_DATA write is accepted at edge k.
  - The FSM pops at edge k+1, and `uart_tx` falls after edge k+1.
  - One frame is 10·`div` cycles.
  - Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- RX latency: `rx_valid` rises about 2 + `div/2` + 9·`div` cycles after the falling edge of the start bit on `uart_rx`.
- `rstn` low at any time, including mid-frame:
  - All state returns to reset values immediately.
  - `uart_tx` goes high asynchronously.

## Test plan
- Reset check: hold `rstn` low, release it, then read 0x04 → 0x00000001. Read 0x10 → 868. `uart_tx` = 1.
- TX frame:
  - Write 0x10 = 8, then 0x00 = 0xA5.
  - `uart_tx` goes low for 8 cycles starting 1 cycle after the write edge, then sends bits 1,0,1,0,0,1,0,1 at 8 cycles each, then high.
  - TX_STAT `busy` clears 80 cycles after the fall.
- FIFO full and overflow:
  - With div = 8, write 18 bytes back to back.
  - The first byte is popped at once, so 16 are queued and 1 is dropped.
  - TX_STAT shows `ready` = 0, count = 16, `ovf` = 1.
  - A second TX_STAT read shows `ovf` = 0.
  - All 17 accepted bytes appear on `uart_tx` in order with no gaps.
- RX loopback and overrun:
  - Connect `uart_tx` to `uart_rx` and send 0x3C.
  - RX_STAT → 0x1; RX_DATA → 0x3C; RX_STAT → 0x0.
  - Send 0x11 then 0x22 without reading → RX_DATA = 0x22, RX_STAT `ovr` = 1.
- Framing error and glitch:
  - Drive a frame with the stop bit low → `ferr` = 1 and `rx_valid` = 0.
  - Drive a 1-cycle low pulse on `uart_rx` → no state change.
- Corner cases:
  - A BAUD_DIV write of 2 reads back as 4.
  - Assert `rstn` low mid-TX-frame → `uart_tx` goes high immediately and the FIFO is empty after release.
